// File: rtl/ro_scan_pkg.sv
// Shared types and defaults for the region readout sequencer.
package ro_scan_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StEmit,
    StDone
  } scan_state_e;

  localparam int unsigned DefNumReg    = 17;
  localparam int unsigned DefNumAddr   = 10;
  localparam int unsigned DefAddrW     = 5;
  localparam int unsigned DefDataW     = 24;
  localparam int unsigned DefSettleCyc = 4;

  // Width of a counter able to hold SettleCyc-1 (never narrower than 1 bit).
  function automatic int unsigned settle_cnt_w(input int unsigned settle_cyc);
    return $clog2(settle_cyc + 1);
  endfunction

endpackage

// File: rtl/ro_scan_sequencer.sv
// Address-major readout of the region array onto a valid/ready stream.
// For every address: broadcast it, wait SettleCyc cycles, then emit one
// word per region tagged with region index and address.
module ro_scan_sequencer
  import ro_scan_pkg::*;
#(
  parameter int unsigned NumReg    = DefNumReg,
  parameter int unsigned NumAddr   = DefNumAddr,
  parameter int unsigned AddrW     = DefAddrW,
  parameter int unsigned DataW     = DefDataW,
  parameter int unsigned SettleCyc = DefSettleCyc
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start_i,
  input  logic                    abort_i,
  output logic [AddrW-1:0]        Addr_o,
  input  logic [NumReg*DataW-1:0] Data_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [DataW-1:0]        out_data_o,
  output logic [4:0]              out_reg_o,
  output logic [AddrW-1:0]        out_addr_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int unsigned     CntW       = settle_cnt_w(SettleCyc);
  localparam logic [CntW-1:0] SettleLoad = CntW'(SettleCyc - 1);
  localparam logic [4:0]      LastReg    = 5'(NumReg - 1);
  localparam logic [AddrW-1:0] LastAddr  = AddrW'(NumAddr - 1);

  scan_state_e     state_q;
  logic [CntW-1:0] cnt_q;

  logic            handshake;
  logic [4:0]      next_reg;
  int unsigned     next_sel;
  logic [DataW-1:0] first_word;
  logic [DataW-1:0] next_word;

  assign handshake  = out_valid_o & out_ready_i;
  assign next_reg   = out_reg_o + 5'd1;
  assign first_word = Data_i[0 +: DataW];
  assign next_word  = Data_i[next_sel*DataW +: DataW];

  // Clamp the mux select so the part-select stays in range on the last region.
  always_comb begin
    next_sel = 0;
    if (32'(next_reg) < NumReg) next_sel = 32'(next_reg);
  end

  // Scan FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      Addr_o      <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_reg_o   <= '0;
      out_addr_o  <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else if (abort_i && (state_q != StIdle)) begin
      // Abort drops any word in flight, including one handshaking this cycle.
      state_q     <= StIdle;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q <= StSettle;
            Addr_o  <= '0;
            cnt_q   <= SettleLoad;
            busy_o  <= 1'b1;
          end
        end
        StSettle: begin
          if (cnt_q == '0) begin
            state_q     <= StEmit;
            out_valid_o <= 1'b1;
            out_data_o  <= first_word;
            out_reg_o   <= '0;
            out_addr_o  <= Addr_o;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StEmit: begin
          if (handshake) begin
            if (out_reg_o != LastReg) begin
              out_data_o <= next_word;
              out_reg_o  <= next_reg;
            end else if (Addr_o != LastAddr) begin
              out_valid_o <= 1'b0;
              Addr_o      <= Addr_o + 1'b1;
              cnt_q       <= SettleLoad;
              state_q     <= StSettle;
            end else begin
              out_valid_o <= 1'b0;
              busy_o      <= 1'b0;
              done_o      <= 1'b1;
              state_q     <= StDone;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/ro_scan_sequencer.md
# ro_scan_sequencer

Readout sequencer that sits directly downstream of the logic-map region array and consumes its per-region 24-bit results. On a start pulse it broadcasts each oscillator address to all regions, waits a fixed settle time, then reads every region's data word in order. Each word is emitted on a valid/ready stream tagged with region index and address. The stream feeds the SoC-side readout FIFO and bus bridge.

## Interface
Parameters:
- NumReg, 17, number of regions scanned (max 32)
- NumAddr, 10, addresses per region, scanned 0..NumAddr-1 (max 32)
- AddrW, 5, region address width
- DataW, 24, region data width
- SettleCyc, 4, cycles Addr_o is held before the first read (min 1)

Ports:
- clk  in  1  single clock; all logic on rising edge; Data_i is synchronous to clk
- rstn  in  1  asynchronous, active-low reset
- start_i  in  1  one-cycle scan request; honoured only in IDLE
- abort_i  in  1  synchronous scan cancel
- Addr_o  out  AddrW  address broadcast to every region Addr_i
- Data_i  in  NumReg*DataW  flat region data; region r occupies bits [r*DataW +: DataW]
- out_valid_o  out  1  stream valid
- out_ready_i  in  1  stream ready
- out_data_o  out  DataW  captured region word
- out_reg_o  out  5  region index of word
- out_addr_o  out  AddrW  address of word
- busy_o  out  1  high in SETTLE and EMIT
- done_o  out  1  one-cycle pulse after the final word is accepted

## Operation
- Scan order: address-major. For a = 0..NumAddr-1, set Addr_o = a, settle, then emit regions r = 0..NumReg-1. Total words = NumReg*NumAddr (170 at default).
- FSM states: IDLE, SETTLE, EMIT, DONE.
  - IDLE -> SETTLE on start_i: Addr_o <= 0, settle counter <= SettleCyc-1.
  - SETTLE: counter decrements each cycle. At zero -> EMIT: out_data_o <= Data_i[reg 0], out_reg_o <= 0, out_addr_o <= Addr_o, out_valid_o <= 1.
  - EMIT, handshake (valid & ready) with r < NumReg-1: load Data_i[r+1], increment out_reg_o, keep valid high.
  - EMIT, handshake with r = NumReg-1 and a < NumAddr-1: out_valid_o <= 0, Addr_o <= a+1, reload counter, -> SETTLE.
  - EMIT, handshake on the last word: out_valid_o <= 0 -> DONE.
  - DONE: done_o = 1 for that cycle -> IDLE.
- Stream rules: while valid is high and ready is low, out_data_o, out_reg_o and out_addr_o are frozen, even if Data_i changes. Valid never drops without a handshake, except on abort or reset.
- Data capture: each word is Data_i sampled at the clock edge that loads it, i.e. the settle end or the preceding handshake.
- start_i outside IDLE is ignored. It does not restart the scan and is not queued.
- abort_i in any non-IDLE state: next cycle IDLE, out_valid_o = 0, busy_o = 0, no done_o. A handshake in the same cycle as abort is lost, and the bench counts it as not delivered. Abort has priority over start in the same cycle.
- Addr_o holds its last value in IDLE and DONE.

## Timing
- Reset values: Addr_o = 0, out_valid_o = 0, out_data_o = 0, out_reg_o = 0, out_addr_o = 0, busy_o = 0, done_o = 0, state IDLE.
- Reset mid-scan: all outputs return to reset values immediately (asynchronous). Rescan requires a new start_i.
- Latency: start_i sampled at edge t0 -> busy_o and the new Addr_o visible at t1. The first valid appears at t1+SettleCyc (t5 at default).
- With out_ready_i held high, each address costs SettleCyc+NumReg cycles. At default the last handshake is at t210 and done_o is high at t211.
- Every output is registered; there are no combinational paths from inputs to outputs.

## Structure
- Package ro_scan_pkg holds:
  - the state enum (IDLE, SETTLE, EMIT, DONE)
  - localparams for default NumReg, NumAddr, AddrW, DataW
  - the settle-counter width $clog2(SettleCyc+1) as a function.
- Single module. The region data mux is an indexed part-select inside it, so no sub-module is needed.
- Top-level integration drives every region Addr_i from Addr_o.

## Test plan
- Full scan, ready = 1, Data_i[r] = {a, r} pattern: 170 words in address-major order with correct tags. First valid at t5, done_o at t211, exactly one done pulse.
- Backpressure: ready toggles pseudo-randomly, and Data_i changes every cycle while stalled. Each word stays frozen until accepted, with no drops or duplicates, and the total is still 170.
- start_i pulsed at cycle 50 of a scan: ignored. Word count stays 170 and the ordering is unchanged.
- abort_i at word 40 with ready = 1: valid is low and busy_o is 0 next cycle, with no done_o. A following start_i restarts from address 0, region 0.
- rstn asserted mid-EMIT while valid is stalled: outputs are 0 immediately. After release, the block idles until start_i.
- NumReg = 1, NumAddr = 1, SettleCyc = 1: one word at t2 and done_o at t3 with ready = 1.
